// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle CPU: sequences IF/ID/EXE/MEM/WB and drives datapath controls.
// Optional CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt the FSM and raise IllegalOp instead of acting as NOPs.
module multicycle_ctrl #(
    parameter int unsigned          OPCODE_W    = 6,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = OPCODE_W'(6'b111111)
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    output logic                PCWre,
    output logic                IRWre,
    output logic                RegWre,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic                ALUSrcB,
    output logic [2:0]          ALUOp,
    output logic [1:0]          ExtSel,
    output logic                DataMemRW,
    output logic                DBDataSrc,
    output logic [1:0]          PCSrc,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic                IllegalOp,
`endif
    output logic [3:0]          State
);

    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_EXE_AL = 4'd2;
    localparam logic [3:0] S_WB_AL  = 4'd3;
    localparam logic [3:0] S_EXE_BR = 4'd4;
    localparam logic [3:0] S_EXE_LS = 4'd5;
    localparam logic [3:0] S_MEM    = 4'd6;
    localparam logic [3:0] S_WB_LD  = 4'd7;
    localparam logic [3:0] S_HALT   = 4'd8;

    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'b000001);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'b010000);
    localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'b010001);
    localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b010010);
    localparam logic [OPCODE_W-1:0] OP_SLL  = OPCODE_W'(6'b011000);
    localparam logic [OPCODE_W-1:0] OP_SLT  = OPCODE_W'(6'b100110);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b110000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b110001);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b110100);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b111000);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] EXT_SHAMT = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_SIGN  = 2'b10;

    logic [3:0] state;
    logic [3:0] state_nxt;

    logic       op_alu, op_rtype, op_imm, op_sll, op_ori;
    logic       op_j, op_beq, op_sw, op_lw, op_halt, op_legal;
    logic [2:0] alu_dec;

    // Opcode decode into instruction-class flags
    always_comb begin : decode
        op_alu   = 1'b0;
        op_rtype = 1'b0;
        op_imm   = 1'b0;
        op_sll   = 1'b0;
        op_ori   = 1'b0;
        op_j     = 1'b0;
        op_beq   = 1'b0;
        op_sw    = 1'b0;
        op_lw    = 1'b0;
        alu_dec  = ALU_ADD;
        op_halt  = (Opcode == HALT_OPCODE);
        case (Opcode)
            OP_ADD:  begin op_alu = 1'b1; op_rtype = 1'b1; end
            OP_SUB:  begin op_alu = 1'b1; op_rtype = 1'b1; alu_dec = ALU_SUB; end
            OP_ADDI: begin op_alu = 1'b1; op_imm = 1'b1; end
            OP_OR:   begin op_alu = 1'b1; op_rtype = 1'b1; alu_dec = ALU_OR; end
            OP_AND:  begin op_alu = 1'b1; op_rtype = 1'b1; alu_dec = ALU_AND; end
            OP_ORI:  begin op_alu = 1'b1; op_imm = 1'b1; op_ori = 1'b1; alu_dec = ALU_OR; end
            OP_SLL:  begin op_alu = 1'b1; op_rtype = 1'b1; op_sll = 1'b1; alu_dec = ALU_SLL; end
            OP_SLT:  begin op_alu = 1'b1; op_rtype = 1'b1; alu_dec = ALU_SLT; end
            OP_SW:   begin op_sw = 1'b1; op_imm = 1'b1; end
            OP_LW:   begin op_lw = 1'b1; op_imm = 1'b1; end
            OP_BEQ:  begin op_beq = 1'b1; alu_dec = ALU_SUB; end
            OP_J:    op_j = 1'b1;
            default: ;
        endcase
        op_legal = op_alu | op_sw | op_lw | op_beq | op_j | op_halt;
    end

    always_ff @(posedge CLK) begin : state_reg
        if (Reset) state <= S_IF;
        else       state <= state_nxt;
    end

    always_comb begin : next_state
        state_nxt = S_IF;
        case (state)
            S_IF: state_nxt = S_ID;
            S_ID: begin
                if (op_halt)     state_nxt = S_HALT;
                else if (op_j)   state_nxt = S_IF;
                else if (op_beq) state_nxt = S_EXE_BR;
                else if (op_sw || op_lw) state_nxt = S_EXE_LS;
                else if (op_alu) state_nxt = S_EXE_AL;
                else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_nxt = S_HALT;
`else
                    state_nxt = S_IF;
`endif
                end
            end
            S_EXE_AL: state_nxt = S_WB_AL;
            S_WB_AL:  state_nxt = S_IF;
            S_EXE_BR: state_nxt = S_IF;
            S_EXE_LS: state_nxt = S_MEM;
            S_MEM:    state_nxt = op_sw ? S_IF : S_WB_LD;
            S_WB_LD:  state_nxt = S_IF;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IF;
        endcase
    end

    // Datapath controls; decode-driven fields stay idle in IF so a stale opcode never leaks out
    always_comb begin : outputs
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = ALU_ADD;
        ExtSel    = EXT_SIGN;
        DataMemRW = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        if (!Reset) begin
            if (state != S_IF) begin
                RegDst  = op_rtype;
                ALUSrcA = op_sll;
                ALUSrcB = op_imm;
                ALUOp   = alu_dec;
                ExtSel  = op_sll ? EXT_SHAMT : (op_ori ? EXT_ZERO : EXT_SIGN);
            end
            case (state)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (op_j) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b11;
                    end
`ifndef CTRL_ILLEGAL_TRAP_EN
                    else if (!op_legal) PCWre = 1'b1;
`endif
                end
                S_EXE_BR: begin
                    PCWre = 1'b1;
                    PCSrc = Zero ? 2'b01 : 2'b00;
                end
                S_WB_AL: begin
                    PCWre  = 1'b1;
                    RegWre = 1'b1;
                end
                S_MEM: begin
                    PCWre     = op_sw;
                    DataMemRW = op_sw;
                end
                S_WB_LD: begin
                    PCWre     = 1'b1;
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky trap flag, set on the edge that leaves ID with an undefined opcode
    always_ff @(posedge CLK) begin : illegal_reg
        if (Reset)                            illegal_q <= 1'b0;
        else if (state == S_ID && !op_legal)  illegal_q <= 1'b1;
    end

    assign IllegalOp = illegal_q;
`endif

    assign State = state;

endmodule
